// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared state encoding and trailing-zero helper for the GCD engine
package gcd_pkg;

    localparam int STATE_W   = 3;
    localparam int CTZ_MAX_W = 64;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_STRIP  = 3'd1,
        ST_REDUCE = 3'd2,
        ST_SCALE  = 3'd3,
        ST_OUT    = 3'd4
    } state_t;

    // Trailing-zero count of the low 'width' bits of x; an all-zero operand yields width.
    function automatic logic [7:0] ctz(input logic [CTZ_MAX_W-1:0] x, input int width);
        logic [7:0] n;
        logic       found;
        n     = 8'(width);
        found = 1'b0;
        for (int i = 0; i < CTZ_MAX_W; i++) begin
            if (!found && (i < width) && x[i]) begin
                n     = 8'(i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/gcd_ctz.sv
// rtl/gcd_ctz.sv - combinational trailing-zero counter
module gcd_ctz
    import gcd_pkg::*;
#(
    parameter int BIT_LEN = 8
) (
    input  logic [BIT_LEN-1:0]            x,
    output logic [$clog2(BIT_LEN+1)-1:0]  zeros
);

    localparam int CW = $clog2(BIT_LEN + 1);

    logic [7:0] full;
    logic       unused_hi;

    // Priority-encode the lowest set bit of the operand.
    always_comb begin
        full = ctz(CTZ_MAX_W'(x), BIT_LEN);
    end

    assign zeros     = full[CW-1:0];
    assign unused_hi = ^full[7:CW];

endmodule

// File: rtl/gcd_engine.sv
// rtl/gcd_engine.sv - binary GCD engine with multi-bit shifts, tag pass-through and abort
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int BIT_LEN   = 8,
    parameter int SHIFT_MAX = BIT_LEN,
    parameter int TAG_W     = 4,
    parameter int CNT_W     = 8
) (
    input  logic               clk_i,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BIT_LEN-1:0] num_0,
    input  logic [BIT_LEN-1:0] num_1,
    input  logic [TAG_W-1:0]   tag_i,
    input  logic               abort,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BIT_LEN-1:0] gcd_op,
    output logic [TAG_W-1:0]   tag_o,
    output logic [CNT_W-1:0]   iter_o,
    output logic               busy
);

    localparam int             CW        = $clog2(BIT_LEN + 1);
    localparam logic [CW-1:0]  SHIFT_LIM = CW'(SHIFT_MAX);

    state_t             state, state_n;
    logic [BIT_LEN-1:0] a, a_n, b, b_n, gcd_n;
    logic [CW-1:0]      k, k_n;
    logic [CNT_W-1:0]   cnt, cnt_n, cnt_inc, iter_n;
    logic [TAG_W-1:0]   tag_r, tag_r_n, tag_o_n;
    logic [CW-1:0]      ctz_a, ctz_b, sa, sb, sh;

    gcd_ctz #(.BIT_LEN(BIT_LEN)) u_ctz_a (.x(a), .zeros(ctz_a));
    gcd_ctz #(.BIT_LEN(BIT_LEN)) u_ctz_b (.x(b), .zeros(ctz_b));

    // Per-operand shift clamped to SHIFT_MAX; the common shift is the smaller of the two.
    assign sa      = (ctz_a < SHIFT_LIM) ? ctz_a : SHIFT_LIM;
    assign sb      = (ctz_b < SHIFT_LIM) ? ctz_b : SHIFT_LIM;
    assign sh      = (sa < sb) ? sa : sb;
    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

    // Handshake flags depend only on the registered state.
    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_OUT);

    // Next-state and datapath updates; abort freezes everything but the state.
    always_comb begin
        state_n = state;
        a_n     = a;
        b_n     = b;
        k_n     = k;
        cnt_n   = cnt;
        tag_r_n = tag_r;
        gcd_n   = gcd_op;
        tag_o_n = tag_o;
        iter_n  = iter_o;
        if (abort) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_n     = num_0;
                        b_n     = num_1;
                        tag_r_n = tag_i;
                        k_n     = '0;
                        cnt_n   = '0;
                        if ((num_0 == '0) || (num_1 == '0)) begin
                            gcd_n   = num_0 | num_1;
                            iter_n  = '0;
                            tag_o_n = tag_i;
                            state_n = ST_OUT;
                        end else begin
                            state_n = ST_STRIP;
                        end
                    end
                end
                ST_STRIP: begin
                    cnt_n = cnt_inc;
                    if (!a[0] && !b[0]) begin
                        a_n = a >> sh;
                        b_n = b >> sh;
                        k_n = k + sh;
                    end else begin
                        state_n = ST_REDUCE;
                    end
                end
                ST_REDUCE: begin
                    cnt_n = cnt_inc;
                    if (!a[0] || !b[0]) begin
                        if (!a[0]) a_n = a >> sa;
                        if (!b[0]) b_n = b >> sb;
                    end else if (a == b) begin
                        state_n = ST_SCALE;
                    end else if (a > b) begin
                        a_n = a - b;
                    end else begin
                        b_n = b - a;
                    end
                end
                ST_SCALE: begin
                    gcd_n   = a << k;
                    iter_n  = cnt;
                    tag_o_n = tag_r;
                    state_n = ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            state  <= ST_IDLE;
            a      <= '0;
            b      <= '0;
            k      <= '0;
            cnt    <= '0;
            tag_r  <= '0;
            gcd_op <= '0;
            tag_o  <= '0;
            iter_o <= '0;
        end else begin
            state  <= state_n;
            a      <= a_n;
            b      <= b_n;
            k      <= k_n;
            cnt    <= cnt_n;
            tag_r  <= tag_r_n;
            gcd_op <= gcd_n;
            tag_o  <= tag_o_n;
            iter_o <= iter_n;
        end
    end

endmodule

// File: tb/tb_gcd_engine.sv
// tb/tb_gcd_engine.sv - scoreboard bench for gcd_engine
module tb_gcd_engine;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    longint cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int gcd;
        int tag;
        int iter;
        int lat;
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];
    exp_t q6[$];

    // main instance: 8-bit, default SHIFT_MAX
    logic       reset, in_valid, abort, out_ready;
    logic [7:0] num_0, num_1;
    logic [3:0] tag_i;
    logic       in_ready, out_valid, busy;
    logic [7:0] gcd_op, iter_o;
    logic [3:0] tag_o;

    // second instance: 8-bit, SHIFT_MAX=1 ; third instance: 6-bit sweep
    logic       reset_x, s1_in_valid, s1_in_ready, s1_out_valid, s1_busy, w6_in_valid, w6_in_ready, w6_out_valid, w6_busy;
    logic       out_ready_x, abort_x;
    logic [7:0] s1_num_0, s1_num_1, s1_gcd, s1_iter, w6_iter;
    logic [5:0] w6_num_0, w6_num_1, w6_gcd;
    logic [3:0] s1_tag_i, s1_tag_o, w6_tag_i, w6_tag_o;

    gcd_engine dut (
        .clk_i(clk_i), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .num_0(num_0), .num_1(num_1), .tag_i(tag_i), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready), .gcd_op(gcd_op),
        .tag_o(tag_o), .iter_o(iter_o), .busy(busy)
    );

    gcd_engine #(.BIT_LEN(8), .SHIFT_MAX(1)) dut_s1 (
        .clk_i(clk_i), .reset(reset_x), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
        .num_0(s1_num_0), .num_1(s1_num_1), .tag_i(s1_tag_i), .abort(abort_x),
        .out_valid(s1_out_valid), .out_ready(out_ready_x), .gcd_op(s1_gcd),
        .tag_o(s1_tag_o), .iter_o(s1_iter), .busy(s1_busy)
    );

    gcd_engine #(.BIT_LEN(6)) dut_w6 (
        .clk_i(clk_i), .reset(reset_x), .in_valid(w6_in_valid), .in_ready(w6_in_ready),
        .num_0(w6_num_0), .num_1(w6_num_1), .tag_i(w6_tag_i), .abort(abort_x),
        .out_valid(w6_out_valid), .out_ready(out_ready_x), .gcd_op(w6_gcd),
        .tag_o(w6_tag_o), .iter_o(w6_iter), .busy(w6_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int gcd_ref(input int x, input int y);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // main monitor: latency, hold stability during backpressure, response scoreboard
    longint acc_cyc = 0;
    bit     seen_v  = 1'b0;
    bit     hold    = 1'b0;
    logic [7:0] h_gcd, h_iter;
    logic [3:0] h_tag;

    always @(negedge clk_i) begin
        if (!reset) begin
            chk("ready_while_busy", {63'd0, in_ready & busy}, 64'd0);
            if (hold && out_valid) begin
                chk("hold_gcd", gcd_op, h_gcd);
                chk("hold_tag", tag_o, h_tag);
                chk("hold_iter", iter_o, h_iter);
                chk("hold_in_ready", in_ready, 0);
            end
            if (out_valid && !seen_v && q8.size() > 0 && q8[0].lat >= 0)
                chk("latency", cyc - acc_cyc, q8[0].lat);
            if (out_valid && out_ready && !abort) begin
                if (q8.size() == 0) begin
                    chk("unexpected_response", 1, 0);
                end else begin
                    chk("gcd", gcd_op, q8[0].gcd);
                    chk("tag", tag_o, q8[0].tag);
                    if (q8[0].iter >= 0) chk("iter", iter_o, q8[0].iter);
                    q8.delete(0);
                end
            end
            seen_v <= out_valid && !(out_ready || abort);
            hold   <= out_valid && !out_ready && !abort;
            h_gcd  <= gcd_op;
            h_tag  <= tag_o;
            h_iter <= iter_o;
        end
    end

    // monitors for the SHIFT_MAX=1 and 6-bit instances
    always @(negedge clk_i) begin
        if (!reset_x) begin
            chk("s1_ready_while_busy", {63'd0, s1_in_ready & s1_busy}, 64'd0);
            chk("w6_ready_while_busy", {63'd0, w6_in_ready & w6_busy}, 64'd0);
            if (s1_out_valid) begin
                if (q1.size() == 0) begin
                    chk("s1_unexpected_response", 1, 0);
                end else begin
                    chk("s1_gcd", s1_gcd, q1[0].gcd);
                    chk("s1_tag", s1_tag_o, q1[0].tag);
                    if (q1[0].iter >= 0) chk("s1_iter", s1_iter, q1[0].iter);
                    q1.delete(0);
                end
            end
            if (w6_out_valid) begin
                if (q6.size() == 0) begin
                    chk("w6_unexpected_response", 1, 0);
                end else begin
                    chk("w6_gcd", w6_gcd, q6[0].gcd);
                    chk("w6_tag", w6_tag_o, q6[0].tag);
                    q6.delete(0);
                end
            end
        end
    end

    task automatic expect8(input int g, input int t, input int it, input int lat);
        q8.push_back('{g, t, it, lat});
    endtask

    task automatic issue8(input int x, input int y, input int t);
        int lim;
        @(posedge clk_i); #1;
        num_0 = 8'(x); num_1 = 8'(y); tag_i = 4'(t); in_valid = 1'b1;
        lim = 0;
        @(negedge clk_i);
        while (!in_ready && lim < 500) begin
            @(negedge clk_i);
            lim++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        acc_cyc = cyc;
        @(posedge clk_i); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain8();
        int lim;
        lim = 0;
        @(negedge clk_i);
        while ((q8.size() != 0 || busy) && lim < 1000) begin
            @(negedge clk_i);
            lim++;
        end
        if (lim >= 1000) chk("drain_timeout", 0, 1);
    endtask

    task automatic issue_s1(input int x, input int y, input int t, input int g, input int it);
        int lim;
        q1.push_back('{g, t, it, -1});
        @(posedge clk_i); #1;
        s1_num_0 = 8'(x); s1_num_1 = 8'(y); s1_tag_i = 4'(t); s1_in_valid = 1'b1;
        lim = 0;
        @(negedge clk_i);
        while (!s1_in_ready && lim < 500) begin
            @(negedge clk_i);
            lim++;
        end
        if (!s1_in_ready) chk("s1_accept_timeout", 0, 1);
        @(posedge clk_i); #1;
        s1_in_valid = 1'b0;
    endtask

    initial begin
        int n_ov;
        reset = 1'b1; reset_x = 1'b1; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
        num_0 = '0; num_1 = '0; tag_i = '0;
        s1_in_valid = 1'b0; s1_num_0 = '0; s1_num_1 = '0; s1_tag_i = '0;
        w6_in_valid = 1'b0; w6_num_0 = '0; w6_num_1 = '0; w6_tag_i = '0;
        out_ready_x = 1'b1; abort_x = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 reset = 1'b0; reset_x = 1'b0;
        @(negedge clk_i);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gcd", gcd_op, 0);
        chk("rst_tag", tag_o, 0);
        chk("rst_iter", iter_o, 0);

        fork
            begin : main_seq
                expect8(6, 5, 6, 8);    issue8(12, 18, 5); drain8();
                expect8(0, 1, 0, 1);    issue8(0, 0, 1);   drain8();
                expect8(35, 2, 0, 1);   issue8(0, 35, 2);  drain8();
                expect8(40, 3, 0, 1);   issue8(40, 0, 3);  drain8();
                expect8(64, 4, 4, -1);  issue8(128, 64, 4); drain8();
                expect8(1, 6, 16, -1);  issue8(255, 1, 6); drain8();

                // backpressure for 10 cycles, then a one-cycle out_ready pulse
                out_ready = 1'b0;
                expect8(6, 7, 6, 8);    issue8(12, 18, 7);
                n_ov = 0;
                while (!out_valid && n_ov < 100) begin
                    @(negedge clk_i);
                    n_ov++;
                end
                chk("bp_valid_seen", out_valid, 1);
                repeat (10) @(negedge clk_i);
                chk("bp_in_ready_low", in_ready, 0);
                chk("bp_still_valid", out_valid, 1);
                @(posedge clk_i); #1 out_ready = 1'b1;
                @(posedge clk_i); #1 out_ready = 1'b0;
                @(negedge clk_i);
                chk("bp_idle_in_ready", in_ready, 1);
                chk("bp_idle_out_valid", out_valid, 0);
                chk("bp_popped", q8.size(), 0);
                out_ready = 1'b1;

                // abort while in REDUCE: no response, then a normal request
                issue8(255, 1, 8);
                @(posedge clk_i); #1;
                @(posedge clk_i); #1 abort = 1'b1;
                @(posedge clk_i); #1 abort = 1'b0;
                @(negedge clk_i);
                chk("abort_busy", busy, 0);
                chk("abort_in_ready", in_ready, 1);
                n_ov = 0;
                repeat (20) begin
                    @(negedge clk_i);
                    if (out_valid) n_ov++;
                end
                chk("abort_no_response", n_ov, 0);
                expect8(3, 9, -1, -1);  issue8(9, 6, 9); drain8();

                // abort in IDLE blocks a simultaneous accept
                @(posedge clk_i); #1;
                num_0 = 8'd5; num_1 = 8'd5; tag_i = 4'd1; in_valid = 1'b1; abort = 1'b1;
                @(posedge clk_i); #1 in_valid = 1'b0; abort = 1'b0;
                @(negedge clk_i);
                chk("idle_abort_busy", busy, 0);

                // abort in OUT with out_ready high discards the response
                out_ready = 1'b0;
                issue8(0, 7, 10);
                @(negedge clk_i);
                chk("out_abort_valid_before", out_valid, 1);
                @(posedge clk_i); #1 abort = 1'b1; out_ready = 1'b1;
                @(posedge clk_i); #1 abort = 1'b0;
                @(negedge clk_i);
                chk("out_abort_valid", out_valid, 0);
                chk("out_abort_in_ready", in_ready, 1);
                chk("out_abort_gcd_kept", gcd_op, 7);
                chk("out_abort_tag_kept", tag_o, 10);

                // reset during STRIP
                issue8(128, 64, 11);
                reset = 1'b1;
                @(posedge clk_i); #1 reset = 1'b0;
                @(negedge clk_i);
                chk("mid_rst_in_ready", in_ready, 1);
                chk("mid_rst_out_valid", out_valid, 0);
                chk("mid_rst_busy", busy, 0);
                chk("mid_rst_gcd", gcd_op, 0);
                chk("mid_rst_tag", tag_o, 0);
                chk("mid_rst_iter", iter_o, 0);
                expect8(6, 12, 6, 8);   issue8(12, 18, 12); drain8();
            end
            begin : s1_seq
                issue_s1(128, 64, 3, 64, 9);
                issue_s1(12, 18, 4, 6, 6);
            end
            begin : w6_seq
                int lim;
                for (int ia = 0; ia < 64; ia++) begin
                    for (int ib = 0; ib < 64; ib++) begin
                        q6.push_back('{gcd_ref(ia, ib), (ia + ib) % 16, -1, -1});
                        @(posedge clk_i); #1;
                        w6_num_0 = 6'(ia); w6_num_1 = 6'(ib); w6_tag_i = 4'((ia + ib) % 16);
                        w6_in_valid = 1'b1;
                        lim = 0;
                        @(negedge clk_i);
                        while (!w6_in_ready && lim < 200) begin
                            @(negedge clk_i);
                            lim++;
                        end
                        if (!w6_in_ready) chk("w6_accept_timeout", 0, 1);
                        @(posedge clk_i); #1;
                        w6_in_valid = 1'b0;
                    end
                end
            end
        join

        repeat (100) @(negedge clk_i);
        chk("q8_empty", q8.size(), 0);
        chk("q1_empty", q1.size(), 0);
        chk("q6_empty", q6.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
